cache_mem_arbiter: RTL and testbench

CACHE_MEM_ARBITER -- requirements
Module: cache_mem_arbiter

---
 rtl/cache_mem_arbiter_if.sv | 43 ++++
 rtl/cache_mem_arbiter.sv | 93 +++++++++
 tb/tb_cache_mem_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_mem_arbiter_if.sv
// Bus bundle between the two L1 caches, the arbiter and the cacheline adaptor.
// The slave view belongs to the arbiter. The master view belongs to its environment.
interface cache_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
);
    logic              icache_read;
    logic [ADDR_W-1:0] icache_addr;
    logic [LINE_W-1:0] icache_rdata;
    logic              icache_resp;

    logic              dcache_read;
    logic              dcache_write;
    logic [ADDR_W-1:0] dcache_addr;
    logic [LINE_W-1:0] dcache_wdata;
    logic [LINE_W-1:0] dcache_rdata;
    logic              dcache_resp;

    logic              pmem_read;
    logic              pmem_write;
    logic [ADDR_W-1:0] pmem_addr;
    logic [LINE_W-1:0] pmem_wdata;
    logic [LINE_W-1:0] pmem_rdata;
    logic              pmem_resp;

    modport slave (
        input  icache_read, icache_addr,
        input  dcache_read, dcache_write, dcache_addr, dcache_wdata,
        input  pmem_rdata, pmem_resp,
        output icache_rdata, icache_resp,
        output dcache_rdata, dcache_resp,
        output pmem_read, pmem_write, pmem_addr, pmem_wdata
    );

    modport master (
        output icache_read, icache_addr,
        output dcache_read, dcache_write, dcache_addr, dcache_wdata,
        output pmem_rdata, pmem_resp,
        input  icache_rdata, icache_resp,
        input  dcache_rdata, dcache_resp,
        input  pmem_read, pmem_write, pmem_addr, pmem_wdata
    );
endinterface

// File: rtl/cache_mem_arbiter.sv
// Arbitrates instruction and data cache line transactions onto a single
// cacheline adaptor port. Contended grants alternate between the two sides.
module cache_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
) (
    input  logic                clk,
    input  logic                rst,
    cache_mem_arbiter_if.slave  bus
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] SERVE_I = 2'd1;
    localparam logic [1:0] SERVE_D = 2'd2;
    localparam logic [1:0] DONE    = 2'd3;

    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

    logic [1:0]        state;
    logic              last_grant;
    logic              pmem_read_q;
    logic              pmem_write_q;
    logic [ADDR_W-1:0] pmem_addr_q;
    logic [LINE_W-1:0] pmem_wdata_q;

    logic i_req;
    logic d_req;
    logic grant_i;

    // Request decode: icache wins when alone or when dcache was served last.
    always_comb begin
        i_req   = bus.icache_read;
        d_req   = bus.dcache_read | bus.dcache_write;
        grant_i = i_req & (~d_req | (last_grant == GRANT_D));
    end

    // FSM, grant history and registered adaptor request/address/data.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            last_grant   <= GRANT_D;
            pmem_read_q  <= 1'b0;
            pmem_write_q <= 1'b0;
            pmem_addr_q  <= '0;
            pmem_wdata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_i) begin
                        state        <= SERVE_I;
                        last_grant   <= GRANT_I;
                        pmem_read_q  <= 1'b1;
                        pmem_write_q <= 1'b0;
                        pmem_addr_q  <= bus.icache_addr;
                    end else if (d_req) begin
                        // A simultaneous read and write is a writeback.
                        state        <= SERVE_D;
                        last_grant   <= GRANT_D;
                        pmem_read_q  <= ~bus.dcache_write;
                        pmem_write_q <= bus.dcache_write;
                        pmem_addr_q  <= bus.dcache_addr;
                        if (bus.dcache_write) begin
                            pmem_wdata_q <= bus.dcache_wdata;
                        end
                    end
                end
                SERVE_I, SERVE_D: begin
                    if (bus.pmem_resp) begin
                        state        <= DONE;
                        pmem_read_q  <= 1'b0;
                        pmem_write_q <= 1'b0;
                    end
                end
                default: begin
                    // DONE gives the owner one cycle to drop its request.
                    state <= IDLE;
                end
            endcase
        end
    end

    // Fill data is broadcast; responses are steered to the current owner.
    always_comb begin
        bus.icache_rdata = bus.pmem_rdata;
        bus.dcache_rdata = bus.pmem_rdata;
        bus.icache_resp  = (state == SERVE_I) & bus.pmem_resp;
        bus.dcache_resp  = (state == SERVE_D) & bus.pmem_resp;
        bus.pmem_read    = pmem_read_q;
        bus.pmem_write   = pmem_write_q;
        bus.pmem_addr    = pmem_addr_q;
        bus.pmem_wdata   = pmem_wdata_q;
    end
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter.
module tb_cache_mem_arbiter;
    localparam int ADDR_W = 32;
    localparam int LINE_W = 256;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    cache_mem_arbiter_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) bus ();

    cache_mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required finish earlier");
        $fatal(1, "watchdog");
    end

    // Advance past the next rising edge; inputs are driven and outputs
    // sampled away from the edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_inputs();
        bus.icache_read  = 1'b0;
        bus.icache_addr  = '0;
        bus.dcache_read  = 1'b0;
        bus.dcache_write = 1'b0;
        bus.dcache_addr  = '0;
        bus.dcache_wdata = '0;
        bus.pmem_rdata   = '0;
        bus.pmem_resp    = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        bus.dcache_write = 1'b1;
        bus.dcache_addr  = 32'h0000_0F00;
        bus.dcache_wdata = {LINE_W{1'b1}};
        rst = 1'b1;
        tick();
        tick();
        settle();
        checks++;
        if (bus.pmem_read !== 1'b0 || bus.pmem_write !== 1'b0) begin
            errors++;
            $display("FAIL reset_req: read=%b write=%b, required 0 0", bus.pmem_read, bus.pmem_write);
        end
        checks++;
        if (bus.pmem_addr !== 32'h0 || bus.pmem_wdata !== {LINE_W{1'b0}}) begin
            errors++;
            $display("FAIL reset_addr_data: addr=%h wdata[31:0]=%h, required 0 0", bus.pmem_addr, bus.pmem_wdata[31:0]);
        end
        clear_inputs();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_icache_read();
        logic [LINE_W-1:0] line;
        line = {8{32'hC0DE_0000}} ^ {{(LINE_W-8){1'b0}}, 8'h5A};
        bus.icache_read = 1'b1;
        bus.icache_addr = 32'h0000_1000;
        tick();
        settle();
        checks++;
        if (bus.pmem_read !== 1'b1 || bus.pmem_write !== 1'b0 || bus.pmem_addr !== 32'h0000_1000) begin
            errors++;
            $display("FAIL icache_grant: read=%b write=%b addr=%h, required 1 0 00001000",
                     bus.pmem_read, bus.pmem_write, bus.pmem_addr);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            settle();
            checks++;
            if (bus.pmem_read !== 1'b1 || bus.icache_resp !== 1'b0 || bus.dcache_resp !== 1'b0) begin
                errors++;
                $display("FAIL icache_wait%0d: read=%b iresp=%b dresp=%b, required 1 0 0",
                         i, bus.pmem_read, bus.icache_resp, bus.dcache_resp);
            end
        end
        bus.pmem_resp  = 1'b1;
        bus.pmem_rdata = line;
        settle();
        checks++;
        if (bus.icache_resp !== 1'b1 || bus.dcache_resp !== 1'b0 || bus.icache_rdata !== line) begin
            errors++;
            $display("FAIL icache_resp: iresp=%b dresp=%b rdata[31:0]=%h, required 1 0 %h",
                     bus.icache_resp, bus.dcache_resp, bus.icache_rdata[31:0], line[31:0]);
        end
        tick();
        // DONE: a stray pmem_resp here must be ignored.
        bus.icache_read = 1'b0;
        settle();
        checks++;
        if (bus.pmem_read !== 1'b0 || bus.icache_resp !== 1'b0 || bus.dcache_resp !== 1'b0) begin
            errors++;
            $display("FAIL icache_done: read=%b iresp=%b dresp=%b, required 0 0 0",
                     bus.pmem_read, bus.icache_resp, bus.dcache_resp);
        end
        bus.pmem_resp = 1'b0;
        tick();
        // IDLE: a stray pmem_resp is ignored and no request appears.
        bus.pmem_resp = 1'b1;
        settle();
        checks++;
        if (bus.icache_resp !== 1'b0 || bus.dcache_resp !== 1'b0) begin
            errors++;
            $display("FAIL idle_resp_ignored: iresp=%b dresp=%b, required 0 0", bus.icache_resp, bus.dcache_resp);
        end
        tick();
        bus.pmem_resp = 1'b0;
        settle();
        checks++;
        if (bus.pmem_read !== 1'b0 || bus.pmem_write !== 1'b0) begin
            errors++;
            $display("FAIL idle_stays: read=%b write=%b, required 0 0", bus.pmem_read, bus.pmem_write);
        end
    endtask

    task automatic test_dcache_write(input logic also_read);
        bus.dcache_write = 1'b1;
        bus.dcache_read  = also_read;
        bus.dcache_addr  = 32'h8000_0040;
        bus.dcache_wdata = {32{8'hA5}};
        tick();
        settle();
        checks++;
        if (bus.pmem_write !== 1'b1 || bus.pmem_read !== 1'b0 || bus.pmem_addr !== 32'h8000_0040
            || bus.pmem_wdata !== {32{8'hA5}}) begin
            errors++;
            $display("FAIL dwrite_grant(rd=%b): write=%b read=%b addr=%h wdata[31:0]=%h, required 1 0 80000040 a5a5a5a5",
                     also_read, bus.pmem_write, bus.pmem_read, bus.pmem_addr, bus.pmem_wdata[31:0]);
        end
        tick();
        bus.pmem_resp = 1'b1;
        settle();
        checks++;
        if (bus.dcache_resp !== 1'b1 || bus.icache_resp !== 1'b0 || bus.pmem_read !== 1'b0) begin
            errors++;
            $display("FAIL dwrite_resp(rd=%b): dresp=%b iresp=%b read=%b, required 1 0 0",
                     also_read, bus.dcache_resp, bus.icache_resp, bus.pmem_read);
        end
        tick();
        bus.pmem_resp    = 1'b0;
        bus.dcache_write = 1'b0;
        bus.dcache_read  = 1'b0;
        bus.dcache_wdata = '0;
        settle();
        checks++;
        if (bus.pmem_write !== 1'b0 || bus.pmem_wdata !== {32{8'hA5}}) begin
            errors++;
            $display("FAIL dwrite_done(rd=%b): write=%b wdata[31:0]=%h, required 0 a5a5a5a5",
                     also_read, bus.pmem_write, bus.pmem_wdata[31:0]);
        end
        tick();
    endtask

    task automatic test_hold_during_serve();
        // Last grant was D, so the contended grant goes to icache.
        bus.icache_read = 1'b1;
        bus.icache_addr = 32'h0000_3000;
        bus.dcache_read = 1'b1;
        bus.dcache_addr = 32'h0000_0100;
        tick();
        for (int i = 0; i < 3; i++) begin
            settle();
            checks++;
            if (bus.pmem_read !== 1'b1 || bus.pmem_write !== 1'b0 || bus.pmem_addr !== 32'h0000_3000) begin
                errors++;
                $display("FAIL hold%0d: read=%b write=%b addr=%h, required 1 0 00003000",
                         i, bus.pmem_read, bus.pmem_write, bus.pmem_addr);
            end
            bus.dcache_addr  = 32'h0000_0200;
            bus.icache_addr  = 32'h0000_4000 + 32'(i * 32'h40);
            bus.dcache_write = (i == 1);
            tick();
        end
        bus.pmem_resp = 1'b1;
        settle();
        checks++;
        if (bus.icache_resp !== 1'b1 || bus.dcache_resp !== 1'b0 || bus.pmem_addr !== 32'h0000_3000) begin
            errors++;
            $display("FAIL hold_resp: iresp=%b dresp=%b addr=%h, required 1 0 00003000",
                     bus.icache_resp, bus.dcache_resp, bus.pmem_addr);
        end
        tick();
        bus.pmem_resp = 1'b0;
        clear_inputs();
        tick();
        tick();
    endtask

    task automatic test_back_to_back();
        logic exp_d;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.icache_read = 1'b1;
        bus.icache_addr = 32'h0000_A000;
        bus.dcache_read = 1'b1;
        bus.dcache_addr = 32'h0000_B000;
        tick();
        for (int k = 0; k < 4; k++) begin
            exp_d = k[0];
            settle();
            checks++;
            if (bus.pmem_read !== 1'b1 || bus.pmem_addr !== (exp_d ? 32'h0000_B000 : 32'h0000_A000)) begin
                errors++;
                $display("FAIL b2b_grant%0d: read=%b addr=%h, required 1 %h",
                         k, bus.pmem_read, bus.pmem_addr, exp_d ? 32'h0000_B000 : 32'h0000_A000);
            end
            tick();
            bus.pmem_resp = 1'b1;
            settle();
            checks++;
            if (bus.icache_resp !== ~exp_d || bus.dcache_resp !== exp_d) begin
                errors++;
                $display("FAIL b2b_resp%0d: iresp=%b dresp=%b, required %b %b",
                         k, bus.icache_resp, bus.dcache_resp, ~exp_d, exp_d);
            end
            tick();
            bus.pmem_resp = 1'b0;
            settle();
            checks++;
            if (bus.pmem_read !== 1'b0) begin
                errors++;
                $display("FAIL b2b_gap1_%0d: read=%b, required 0", k, bus.pmem_read);
            end
            tick();
            settle();
            checks++;
            if (bus.pmem_read !== 1'b0) begin
                errors++;
                $display("FAIL b2b_gap2_%0d: read=%b, required 0", k, bus.pmem_read);
            end
            tick();
        end
        // After four transactions the fifth request is back on icache.
        settle();
        checks++;
        if (bus.pmem_read !== 1'b1 || bus.pmem_addr !== 32'h0000_A000) begin
            errors++;
            $display("FAIL b2b_grant4: read=%b addr=%h, required 1 0000a000", bus.pmem_read, bus.pmem_addr);
        end
        clear_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset_mid();
        bus.dcache_read = 1'b1;
        bus.dcache_addr = 32'h0000_0500;
        tick();
        tick();
        settle();
        checks++;
        if (bus.pmem_read !== 1'b1 || bus.pmem_addr !== 32'h0000_0500) begin
            errors++;
            $display("FAIL mid_pre: read=%b addr=%h, required 1 00000500", bus.pmem_read, bus.pmem_addr);
        end
        rst = 1'b1;
        bus.dcache_read = 1'b0;
        tick();
        rst = 1'b0;
        settle();
        checks++;
        if (bus.pmem_read !== 1'b0 || bus.pmem_write !== 1'b0 || bus.pmem_addr !== 32'h0) begin
            errors++;
            $display("FAIL mid_reset: read=%b write=%b addr=%h, required 0 0 0",
                     bus.pmem_read, bus.pmem_write, bus.pmem_addr);
        end
        bus.pmem_resp = 1'b1;
        settle();
        checks++;
        if (bus.dcache_resp !== 1'b0 || bus.icache_resp !== 1'b0) begin
            errors++;
            $display("FAIL mid_late_resp: dresp=%b iresp=%b, required 0 0", bus.dcache_resp, bus.icache_resp);
        end
        tick();
        bus.pmem_resp   = 1'b0;
        bus.icache_read = 1'b1;
        bus.icache_addr = 32'h0000_0700;
        tick();
        settle();
        checks++;
        if (bus.pmem_read !== 1'b1 || bus.pmem_addr !== 32'h0000_0700) begin
            errors++;
            $display("FAIL mid_idle_grant: read=%b addr=%h, required 1 00000700", bus.pmem_read, bus.pmem_addr);
        end
        clear_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        clear_inputs();
        test_reset();
        test_icache_read();
        test_dcache_write(1'b0);
        test_dcache_write(1'b1);
        test_hold_during_serve();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
